// File: rtl/updown_rx.sv
// Receive-side checker for the up/down counter display: decodes the direction glyph and validates each count step.
// Two-cycle latency from input to result pulses; no backpressure. Optional wrap counter under UPDOWN_RX_WRAP_CNT_EN.
module updown_rx #(
  parameter int RELOCK = 4,
  parameter int ERR_W  = 8
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [3:0]       in_count,
  input  logic [6:0]       in_segment,
  input  logic             in_digit,
  output logic             dir_up,
  output logic             dir_valid,
  output logic             step_ok,
  output logic             step_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       wrap_cnt
);

  localparam logic [6:0] SEG_UP   = 7'b0111110;
  localparam logic [6:0] SEG_DN   = 7'b1011110;
  localparam logic [3:0] RELOCK_V = 4'(RELOCK);

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_ERROR} state_t;
  typedef enum logic [1:0] {G_UP, G_DN, G_CLR, G_BAD} glyph_t;

  logic [3:0]       s1_count_q, s1_count_d;
  logic [6:0]       s1_seg_q, s1_seg_d;
  logic             s1_digit_q, s1_digit_d;
  logic             s1_vld_q, s1_vld_d;
  logic [3:0]       s2_count_q, s2_count_d;
  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             dir_up_q, dir_up_d;
  logic             dir_valid_q, dir_valid_d;
  logic             step_ok_q, step_ok_d;
  logic             step_err_q, step_err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  glyph_t     glyph;
  logic [3:0] exp_count;
  logic       match;
  logic       is_wrap;
  logic [3:0] run_inc;

  // Glyph decode; a lit digit with a blank glyph (or vice versa) is treated as corrupt.
  always_comb begin
    glyph = G_BAD;
    case (s1_seg_q)
      SEG_UP:  glyph = G_UP;
      SEG_DN:  glyph = G_DN;
      7'b0:    glyph = G_CLR;
      default: glyph = G_BAD;
    endcase
    if (s1_digit_q != (|s1_seg_q)) begin
      glyph = G_BAD;
    end
  end

  always_comb begin
    case (glyph)
      G_UP:    exp_count = s2_count_q + 4'd1;
      G_DN:    exp_count = s2_count_q - 4'd1;
      default: exp_count = 4'd0;
    endcase
    match   = (glyph != G_BAD) && (s1_count_q == exp_count);
    is_wrap = match && (((glyph == G_UP) && (s2_count_q == 4'd15)) ||
                        ((glyph == G_DN) && (s2_count_q == 4'd0)));
    run_inc = run_q + 4'd1;
  end

  always_comb begin
    s1_count_d  = in_count;
    s1_seg_d    = in_segment;
    s1_digit_d  = in_digit;
    s1_vld_d    = 1'b1;
    s2_count_d  = s1_count_q;
    state_d     = state_q;
    run_d       = run_q;
    dir_up_d    = dir_up_q;
    dir_valid_d = dir_valid_q;
    step_ok_d   = 1'b0;
    step_err_d  = 1'b0;
    wrap_d      = 1'b0;
    err_cnt_d   = err_cnt_q;

    if ((state_q != ST_IDLE) && ((glyph == G_UP) || (glyph == G_DN))) begin
      dir_up_d    = (glyph == G_UP);
      dir_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // The first sample after reset only seeds history; S1 holds reset junk until then.
        if (s1_vld_q && (glyph != G_BAD)) begin
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (match) begin
          step_ok_d = 1'b1;
          wrap_d    = is_wrap;
          if (glyph == G_CLR) begin
            dir_valid_d = 1'b0;
          end
        end else begin
          step_err_d = 1'b1;
          state_d    = ST_ERROR;
          run_d      = 4'd0;
        end
      end
      default: begin
        if (!match) begin
          step_err_d = 1'b1;
          run_d      = 4'd0;
        end else if (glyph == G_CLR) begin
          state_d     = ST_TRACK;
          dir_valid_d = 1'b0;
          run_d       = 4'd0;
        end else if (run_inc == RELOCK_V) begin
          state_d = ST_TRACK;
          run_d   = 4'd0;
        end else begin
          run_d = run_inc;
        end
      end
    endcase

    if (step_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_count_q  <= 4'd0;
      s1_seg_q    <= 7'd0;
      s1_digit_q  <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_count_q  <= 4'd0;
      state_q     <= ST_IDLE;
      run_q       <= 4'd0;
      dir_up_q    <= 1'b0;
      dir_valid_q <= 1'b0;
      step_ok_q   <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_count_q  <= s1_count_d;
      s1_seg_q    <= s1_seg_d;
      s1_digit_q  <= s1_digit_d;
      s1_vld_q    <= s1_vld_d;
      s2_count_q  <= s2_count_d;
      state_q     <= state_d;
      run_q       <= run_d;
      dir_up_q    <= dir_up_d;
      dir_valid_q <= dir_valid_d;
      step_ok_q   <= step_ok_d;
      step_err_q  <= step_err_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef UPDOWN_RX_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q + (wrap_d ? 8'd1 : 8'd0);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt_q <= 8'd0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  assign wrap_cnt = 8'd0;
`endif

  assign dir_up    = dir_up_q;
  assign dir_valid = dir_valid_q;
  assign step_ok   = step_ok_q;
  assign step_err  = step_err_q;
  assign wrap      = wrap_q;
  assign locked    = (state_q == ST_TRACK);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_updown_rx.sv
// Bench for updown_rx: per-sample reference model with a two-sample result delay, scenario tasks plus random traffic.
module tb_updown_rx;

  localparam int RELOCK = 4;
  localparam logic [6:0] SEG_UP = 7'b0111110;
  localparam logic [6:0] SEG_DN = 7'b1011110;
  localparam logic [6:0] SEG_XX = 7'b1111111;
`ifdef UPDOWN_RX_WRAP_CNT_EN
  localparam int WRAP_EN = 1;
`else
  localparam int WRAP_EN = 0;
`endif

  typedef struct packed {
    logic       dir_up;
    logic       dir_valid;
    logic       step_ok;
    logic       step_err;
    logic       wrap;
    logic       locked;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
  } res_t;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [3:0] in_count;
  logic [6:0] in_segment;
  logic       in_digit;
  logic       dir_up, dir_valid, step_ok, step_err, wrap, locked;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  updown_rx #(.RELOCK(RELOCK), .ERR_W(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .in_count(in_count), .in_segment(in_segment),
    .in_digit(in_digit), .dir_up(dir_up), .dir_valid(dir_valid), .step_ok(step_ok),
    .step_err(step_err), .wrap(wrap), .locked(locked), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: one call per sample, outputs as they should look once that sample is judged.
  localparam int MD_IDLE = 0, MD_TRACK = 1, MD_ERR = 2;
  localparam int G_UP = 0, G_DN = 1, G_CLR = 2, G_BAD = 3;
  int   m_mode, m_prev, m_run, m_err, m_wrap;
  bit   m_dir_up, m_dir_valid;
  res_t pend[$];
  res_t exp_now;

  function automatic res_t obs();
    return {dir_up, dir_valid, step_ok, step_err, wrap, locked, err_cnt, wrap_cnt};
  endfunction

  function automatic void model_reset();
    m_mode = MD_IDLE; m_prev = 0; m_run = 0; m_err = 0; m_wrap = 0;
    m_dir_up = 0; m_dir_valid = 0;
    pend.delete();
    exp_now = '0;
  endfunction

  function automatic res_t model(input logic [3:0] c, input logic [6:0] s, input logic d);
    int   g, want;
    bit   good;
    res_t r;
    r = '0;
    if (d != (s != 7'd0))     g = G_BAD;
    else if (s == SEG_UP)     g = G_UP;
    else if (s == SEG_DN)     g = G_DN;
    else if (s == 7'd0)       g = G_CLR;
    else                      g = G_BAD;
    want = (g == G_UP) ? (m_prev + 1) % 16 : (g == G_DN) ? (m_prev + 15) % 16 : 0;
    good = (g != G_BAD) && (int'(c) == want);
    if (m_mode != MD_IDLE && (g == G_UP || g == G_DN)) begin
      m_dir_up = (g == G_UP);
      m_dir_valid = 1;
    end
    if (m_mode == MD_IDLE) begin
      if (g != G_BAD) m_mode = MD_TRACK;
    end else if (m_mode == MD_TRACK) begin
      if (good) begin
        r.step_ok = 1;
        r.wrap = (g == G_UP && m_prev == 15) || (g == G_DN && m_prev == 0);
        if (g == G_CLR) m_dir_valid = 0;
      end else begin
        r.step_err = 1;
        m_mode = MD_ERR;
        m_run = 0;
      end
    end else begin
      if (!good) begin
        r.step_err = 1;
        m_run = 0;
      end else if (g == G_CLR) begin
        m_mode = MD_TRACK;
        m_dir_valid = 0;
      end else begin
        m_run++;
        if (m_run == RELOCK) m_mode = MD_TRACK;
      end
    end
    if (r.step_err && m_err < 255) m_err++;
    if (r.wrap && WRAP_EN == 1) m_wrap = (m_wrap + 1) % 256;
    m_prev = int'(c);
    r.dir_up = m_dir_up;
    r.dir_valid = m_dir_valid;
    r.locked = (m_mode == MD_TRACK);
    r.err_cnt = 8'(m_err);
    r.wrap_cnt = 8'(m_wrap);
    return r;
  endfunction

  // Drive one sample starting at a falling edge; return at the next falling edge with exp_now current.
  task automatic drive(input logic [3:0] c, input logic [6:0] s, input logic d);
    in_count = c; in_segment = s; in_digit = d;
    pend.push_back(model(c, s, d));
    @(posedge CLK);
    #1;
    if (pend.size() > 1) exp_now = pend.pop_front();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_count = 4'd0; in_segment = 7'd0; in_digit = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_count = 4'd9; in_segment = SEG_UP; in_digit = 1'b1;
    #3;
    checks++;
    if (obs() !== res_t'(0)) begin errors++; $display("FAIL reset_async: got %h want 0", obs()); end
    do_reset();
    checks++;
    if (obs() !== res_t'(0)) begin errors++; $display("FAIL reset_state: got %h want 0", obs()); end
  endtask

  task automatic test_up_count();
    int n_ok = 0, n_wrap = 0, n_err = 0;
    for (int i = 0; i < 18; i++) begin
      drive(4'(i % 16), SEG_UP, 1'b1);
      checks++;
      if (obs() !== exp_now) begin errors++; $display("FAIL up_seq[%0d]: got %h want %h", i, obs(), exp_now); end
      if (i == 1) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL up_lock: got %b want 1", locked); end
      end
      n_ok += int'(step_ok); n_wrap += int'(wrap); n_err += int'(step_err);
    end
    checks++;
    if (n_ok != 16) begin errors++; $display("FAIL up_ok_count: got %0d want 16", n_ok); end
    checks++;
    if (n_wrap != 1 || n_err != 0) begin errors++; $display("FAIL up_wrap_err: got wrap=%0d err=%0d want 1/0", n_wrap, n_err); end
    checks++;
    if (err_cnt !== 8'd0 || wrap_cnt !== 8'(WRAP_EN)) begin
      errors++; $display("FAIL up_counters: got err=%0d wrapc=%0d want 0/%0d", err_cnt, wrap_cnt, WRAP_EN);
    end
  endtask

  task automatic test_down();
    logic [3:0] cnt [9] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    int n_wrap = 0, n_err = 0;
    for (int i = 0; i < 9; i++) begin
      drive(cnt[i], (i < 3) ? SEG_UP : SEG_DN, 1'b1);
      checks++;
      if (obs() !== exp_now) begin errors++; $display("FAIL down_seq[%0d]: got %h want %h", i, obs(), exp_now); end
      n_wrap += int'(wrap); n_err += int'(step_err);
    end
    checks++;
    if (dir_up !== 1'b0 || dir_valid !== 1'b1) begin errors++; $display("FAIL down_dir: got %b%b want 01", dir_up, dir_valid); end
    checks++;
    if (n_wrap != 1 || n_err != 0) begin errors++; $display("FAIL down_wrap_err: got wrap=%0d err=%0d want 1/0", n_wrap, n_err); end
  endtask

  task automatic test_jump();
    logic [3:0] cnt [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    int n_ok_err = 0;
    for (int i = 0; i < 12; i++) begin
      drive(cnt[i], (i == 0) ? 7'd0 : SEG_UP, (i == 0) ? 1'b0 : 1'b1);
      checks++;
      if (obs() !== exp_now) begin errors++; $display("FAIL jump_seq[%0d]: got %h want %h", i, obs(), exp_now); end
      if (i == 7) begin
        checks++;
        if (step_err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1) begin
          errors++; $display("FAIL jump_err: got err=%b lock=%b cnt=%0d want 1/0/1", step_err, locked, err_cnt);
        end
      end
      if (i >= 8 && i <= 11) n_ok_err += int'(step_ok);
      if (i == 10) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL jump_early_lock: got %b want 0", locked); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL jump_relock: got %b want 1", locked); end
    checks++;
    if (n_ok_err != 0) begin errors++; $display("FAIL jump_ok_in_error: got %0d want 0", n_ok_err); end
  endtask

  task automatic test_bad_glyph();
    logic [6:0] seg [4] = '{SEG_DN, SEG_XX, SEG_UP, SEG_XX};
    logic       dig [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(4'(11 - i), seg[i], dig[i]);
      checks++;
      if (obs() !== exp_now) begin errors++; $display("FAIL bad_seq[%0d]: got %h want %h", i, obs(), exp_now); end
      if (i >= 2) begin
        checks++;
        if (step_err !== 1'b1 || dir_up !== 1'b0 || dir_valid !== 1'b1) begin
          errors++; $display("FAIL bad_glyph[%0d]: got err=%b dir=%b%b want 1/01", i, step_err, dir_up, dir_valid);
        end
      end
    end
  endtask

  task automatic test_clr_in_error();
    drive(4'd0, 7'd0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL clr_pre: got locked=%b want 0", locked); end
    drive(4'd1, SEG_UP, 1'b1);
    checks++;
    if (obs() !== exp_now) begin errors++; $display("FAIL clr_seq: got %h want %h", obs(), exp_now); end
    checks++;
    if (locked !== 1'b1 || dir_valid !== 1'b0) begin errors++; $display("FAIL clr_relock: got lock=%b dv=%b want 1/0", locked, dir_valid); end
  endtask

  task automatic test_random();
    int g_cnt = 1;
    bit g_up = 1;
    logic [6:0] s;
    logic d;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      s = g_up ? SEG_UP : SEG_DN; d = 1'b1;
      if (r < 65) begin
        g_cnt = (g_cnt + (g_up ? 1 : 15)) % 16;
      end else if (r < 72) begin
        g_up = !g_up; s = g_up ? SEG_UP : SEG_DN;
        g_cnt = (g_cnt + (g_up ? 1 : 15)) % 16;
      end else if (r < 80) begin
        g_cnt = $urandom_range(0, 15);
      end else if (r < 86) begin
        g_cnt = $urandom_range(0, 15); s = 7'($urandom); d = 1'($urandom);
      end else if (r < 93) begin
        g_cnt = 0; s = 7'd0; d = 1'b0;
      end else begin
        g_cnt = (g_cnt + (g_up ? 1 : 15)) % 16; d = 1'b0;
      end
      drive(4'(g_cnt), s, d);
      checks++;
      if (obs() !== exp_now) begin errors++; $display("FAIL rand[%0d]: got %h want %h", i, obs(), exp_now); end
    end
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), SEG_XX, 1'b1);
      checks++;
      if (obs() !== exp_now) begin errors++; $display("FAIL sat_seq[%0d]: got %h want %h", i, obs(), exp_now); end
    end
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== res_t'(0)) begin errors++; $display("FAIL midstream_reset: got %h want 0", obs()); end
    @(negedge CLK);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'(5 + i), SEG_UP, 1'b1);
      checks++;
      if (obs() !== exp_now) begin errors++; $display("FAIL post_reset[%0d]: got %h want %h", i, obs(), exp_now); end
    end
    checks++;
    if (locked !== 1'b1 || step_ok !== 1'b1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL post_reset_state: got lock=%b ok=%b err=%0d want 1/1/0", locked, step_ok, err_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_count();
    test_down();
    test_jump();
    test_bad_glyph();
    test_clr_in_error();
    test_random();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
